// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation select and FSM states.
// Pure declarations; no latency or flow-control of its own.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage request/result bundle between the pipeline and the multiply/divide unit.
// Start is sampled only while the unit is idle; upstream holds it while BusyE is high.
interface mdu_if #(
    parameter int DATA_W = 32
);
    logic              StartE;
    logic [1:0]        MDControlE;
    logic [DATA_W-1:0] SrcAE;
    logic [DATA_W-1:0] SrcBE;
    logic              BusyE;
    logic              DoneE;
    logic              DivZeroE;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (
        output StartE, MDControlE, SrcAE, SrcBE,
        input  BusyE, DoneE, DivZeroE, HI, LO
    );

    modport slave (
        input  StartE, MDControlE, SrcAE, SrcBE,
        output BusyE, DoneE, DivZeroE, HI, LO
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// Operand magnitude extraction and final sign correction for signed multiply/divide.
// Purely combinational, zero latency; no flow control.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  md_op_e            op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] mag_a_o,
    output logic [DATA_W-1:0] mag_b_o,
    output logic              neg_res_o,
    output logic              neg_rem_o,

    input  logic              fix_div_i,
    input  logic              fix_neg_res_i,
    input  logic              fix_neg_rem_i,
    input  logic [DATA_W-1:0] raw_hi_i,
    input  logic [DATA_W-1:0] raw_lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic                neg_a;
    logic                neg_b;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;

    always_comb begin
        neg_a     = op_is_signed(op_i) & a_i[DATA_W-1];
        neg_b     = op_is_signed(op_i) & b_i[DATA_W-1];
        mag_a_o   = neg_a ? -a_i : a_i;
        mag_b_o   = neg_b ? -b_i : b_i;
        neg_res_o = neg_a ^ neg_b;
        // Truncating division: remainder follows the dividend's sign.
        neg_rem_o = neg_a & op_is_div(op_i);
    end

    always_comb begin
        prod     = {raw_hi_i, raw_lo_i};
        prod_fix = fix_neg_res_i ? -prod : prod;
        if (fix_div_i) begin
            hi_o = fix_neg_rem_i ? -raw_hi_i : raw_hi_i;
            lo_o = fix_neg_res_i ? -raw_lo_i : raw_lo_i;
        end else begin
            hi_o = prod_fix[2*DATA_W-1:DATA_W];
            lo_o = prod_fix[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiply / restoring divide, one result bit per cycle, HI/LO result registers.
// Latency DATA_W+1 cycles (1 on divide-by-zero); requests are ignored while RUN/DONE, upstream holds them.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic   CLK,
    input  logic   RST,
    mdu_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              div_q, div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    md_op_e            start_op;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic              st_neg_res;
    logic              st_neg_rem;
    logic [DATA_W-1:0] iter_hi;
    logic [DATA_W-1:0] iter_lo;
    logic [DATA_W-1:0] fix_hi;
    logic [DATA_W-1:0] fix_lo;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W-1:0] rem_sub;
    logic              rem_ge;

    assign start_op = md_op_e'(bus.MDControlE);

    mdu_sign_fix #(
        .DATA_W (DATA_W)
    ) u_sign_fix (
        .op_i          (start_op),
        .a_i           (bus.SrcAE),
        .b_i           (bus.SrcBE),
        .mag_a_o       (mag_a),
        .mag_b_o       (mag_b),
        .neg_res_o     (st_neg_res),
        .neg_rem_o     (st_neg_rem),
        .fix_div_i     (div_q),
        .fix_neg_res_i (neg_res_q),
        .fix_neg_rem_i (neg_rem_q),
        .raw_hi_i      (iter_hi),
        .raw_lo_i      (iter_lo),
        .hi_o          (fix_hi),
        .lo_o          (fix_lo)
    );

    // Multiply: {acc_hi, acc_lo} holds partial product over the unconsumed multiplier bits.
    // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_hi_q, acc_lo_q[DATA_W-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        rem_sub = rem_sh[DATA_W-1:0] - opnd_q;
        if (div_q) begin
            iter_hi = rem_ge ? rem_sub : rem_sh[DATA_W-1:0];
            iter_lo = {acc_lo_q[DATA_W-2:0], rem_ge};
        end else begin
            iter_hi = mul_sum[DATA_W:1];
            iter_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.StartE) begin
                    div_d     = op_is_div(start_op);
                    neg_res_d = st_neg_res;
                    neg_rem_d = st_neg_rem;
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    if (op_is_div(start_op) && (bus.SrcBE == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = RUN;
                        if (op_is_div(start_op)) begin
                            acc_lo_d = mag_a;
                            opnd_d   = mag_b;
                        end else begin
                            acc_lo_d = mag_b;
                            opnd_d   = mag_a;
                        end
                    end
                end
            end
            RUN: begin
                acc_hi_d = iter_hi;
                acc_lo_d = iter_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.BusyE    = (state_q == RUN);
    assign bus.DoneE    = (state_q == DONE);
    assign bus.DivZeroE = (state_q == DONE) & dz_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic CLK;
    logic RST;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    mdu_if #(.DATA_W(32)) bus ();

    mul_div_unit #(.DATA_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one operation, given current HI/LO.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint      sa, sb, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = mdl_hi;
        lo = mdl_lo;
        dz = 1'b0;
        case (op)
            OP_MULT: begin
                sr = sa * sb;
                hi = sr[63:32];
                lo = sr[31:0];
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    sr = sa / sb;
                    lo = sr[31:0];
                    sr = sa % sb;
                    hi = sr[31:0];
                end
            end
            default: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    // Issue one request from IDLE and follow it to completion. With hold set, StartE stays
    // high carrying junk operands for the whole operation and is left high on return.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input string tag);
        logic [31:0] e_hi, e_lo;
        bit          e_dz, got_done, dz_seen, overlap, stable;
        int          cyc, busy_cyc, done_cyc;
        model(op, a, b, e_hi, e_lo, e_dz);
        got_done = 0; dz_seen = 0; overlap = 0; stable = 1;
        cyc = 0; busy_cyc = 0; done_cyc = -1;

        @(negedge CLK);
        bus.StartE     = 1'b1;
        bus.MDControlE = op;
        bus.SrcAE      = a;
        bus.SrcBE      = b;
        @(posedge CLK);
        #1;
        if (hold) begin
            bus.SrcAE      = $urandom;
            bus.SrcBE      = $urandom;
            bus.MDControlE = 2'($urandom);
        end else begin
            bus.StartE = 1'b0;
        end

        while (!got_done && cyc < 80) begin
            if (bus.BusyE && bus.DoneE) overlap = 1;
            if (bus.BusyE) busy_cyc++;
            if (bus.DoneE) begin
                got_done = 1;
                done_cyc = cyc;
                dz_seen  = bus.DivZeroE;
            end else begin
                if (bus.HI !== mdl_hi || bus.LO !== mdl_lo) stable = 0;
                @(posedge CLK);
                #1;
                cyc++;
            end
        end

        check({tag, " done_seen"}, 64'(got_done), 64'd1);
        check({tag, " done_latency"}, 64'(done_cyc), e_dz ? 64'd0 : 64'd32);
        check({tag, " busy_cycles"}, 64'(busy_cyc), e_dz ? 64'd0 : 64'd32);
        check({tag, " divzero"}, 64'(dz_seen), 64'(e_dz));
        check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, " hilo_stable"}, 64'(stable), 64'd1);
        check({tag, " HI"}, 64'(bus.HI), 64'(e_hi));
        check({tag, " LO"}, 64'(bus.LO), 64'(e_lo));

        @(posedge CLK);
        #1;
        check({tag, " after_done busy/done/dz"}, {61'd0, bus.BusyE, bus.DoneE, bus.DivZeroE}, 64'd0);
        mdl_hi = e_hi;
        mdl_lo = e_lo;
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        bit          done_during_rst;

        mdl_hi = '0;
        mdl_lo = '0;
        RST            = 1'b0;
        bus.StartE     = 1'b0;
        bus.MDControlE = 2'b00;
        bus.SrcAE      = '0;
        bus.SrcBE      = '0;
        #1;
        check("reset outputs", {bus.BusyE, bus.DoneE, bus.DivZeroE, 61'd0}, 64'd0);
        check("reset HI", 64'(bus.HI), 64'd0);
        check("reset LO", 64'(bus.LO), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         0, "mult_neg3x7");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, "mult_minxmin");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, "div_neg7by2");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
        run_op(OP_DIVU,  32'd7,         32'd2,         0, "divu_7by2");
        run_op(OP_DIVU,  32'h1234_5678, 32'd0,         0, "divu_by_zero");
        check("divzero kept HI", 64'(bus.HI), 64'd1);
        check("divzero kept LO", 64'(bus.LO), 64'd3);
        run_op(OP_DIV,   32'h0000_0009, 32'd0,         0, "div_by_zero");

        // StartE held through RUN/DONE with junk, then the next request is taken from IDLE.
        run_op(OP_MULT,  32'hFFFF_FF00, 32'h0001_2345, 1, "hold_first");
        run_op(OP_DIV,   32'h7654_3210, 32'hFFFF_FFF3, 0, "hold_second");

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 5) == 0) r_b = 32'd0;
            else if ($urandom_range(0, 4) == 0) r_b = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 6) == 0) r_a = 32'h8000_0000;
            run_op(r_op, r_a, r_b, 0, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of an operation.
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, "pre_reset");
        @(negedge CLK);
        bus.StartE     = 1'b1;
        bus.MDControlE = OP_MULTU;
        bus.SrcAE      = $urandom;
        bus.SrcBE      = $urandom;
        @(posedge CLK);
        #1;
        bus.StartE = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        check("mid-run busy before reset", 64'(bus.BusyE), 64'd1);
        RST = 1'b0;
        #1;
        check("async reset busy/done/dz", {61'd0, bus.BusyE, bus.DoneE, bus.DivZeroE}, 64'd0);
        check("async reset HI", 64'(bus.HI), 64'd0);
        check("async reset LO", 64'(bus.LO), 64'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        done_during_rst = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (bus.DoneE || bus.BusyE) done_during_rst = 1;
        end
        check("no completion after reset", 64'(done_during_rst), 64'd0);
        run_op(OP_MULTU, 32'd5, 32'd6, 0, "post_reset_5x6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
